proj_fm_ctrl: RTL and testbench
===============================

Name: proj_fm_ctrl

Overview:
Buffer scheduler for the multi-buffer genome frame memory (FM). Accepts a byte stream with valid/ready and issues registered write commands (buffer, address, data) into the FM. It tracks the state of every buffer and issues read-window commands (buffer, base address) to the minhash front-end. A buffer is freed once its last window has been consumed.

Parameters:
BUFFER_COUNT, 4, number of FM buffers (proj_pkg::FM_BUFFER_COUNT)
RAMS, 4, RAMs per buffer (proj_pkg::FM_RAMS_COUNT)
ENTRIES, 16, entries per RAM (proj_pkg::FM_ENTRIES_COUNT)
OFFSET, 4, bytes per entry (proj_pkg::FM_OFFSET_COUNT)
DATA_BITS, 8, genome byte width (proj_pkg::FM_GENOME_BTYE)
READ_ADDRESSES_COUNT, 8, bytes per read window (RAC)
STRIDE, 1, base-address step between consecutive windows
Derived: CAP=RAMS*ENTRIES*OFFSET (256); AW=$clog2(CAP); BW=$clog2(BUFFER_COUNT)

Ports:
in_clk  input  1  clock
in_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input byte valid
in_wdata  input  DATA_BITS  genome byte
in_last  input  1  last byte of sequence; seals the current buffer early
out_ready  output  1  controller can accept a byte
out_wr_en  output  1  FM write strobe
out_wr_buf  output  BW  FM buffer index for the write
out_wr_addr  output  AW  byte address within the buffer
out_wr_data  output  DATA_BITS  byte to write
out_rd_valid  output  1  read window valid
in_rd_ready  input  1  consumer accepts the window
out_rd_buf  output  BW  buffer index of the window
out_rd_addr  output  AW  window base address
out_short  output  1  one-cycle pulse: buffer sealed with fill<RAC, no windows issued
out_full_count  output  BW+1  number of buffers in FULL or READING

Behaviour:
- Per-buffer state: FREE, FILLING, FULL, READING. Each buffer also stores fill (AW+1 bits).
- Write pointer wr_idx and read pointer rd_idx both rotate mod BUFFER_COUNT. Buffers are always read in write order.
- Reset (asynchronous): all buffers FREE, fills 0, wr_idx=rd_idx=0, wr_addr=0, rd_base=0. Outputs: out_wr_en=0, out_rd_valid=0, out_short=0, out_full_count=0, all bus outputs 0. out_ready=1 (combinational, since all buffers are FREE).
- out_ready = state[wr_idx] is FREE or FILLING. It is combinational from registered state, with no dependence on in_valid.
- Accept = in_valid && out_ready. On accept:
  - state[wr_idx] becomes FILLING.
  - Next cycle: out_wr_en=1, out_wr_buf=wr_idx, out_wr_addr=wr_addr, out_wr_data=in_wdata (1-cycle latency, all registered).
  - wr_addr increments.
- Seal condition: accepted byte has wr_addr==CAP-1, or in_last=1. On seal:
  - fill = wr_addr+1; state becomes FULL.
  - wr_idx advances; wr_addr returns to 0.
  - in_last without accept is ignored.
- Read side:
  - When state[rd_idx]==FULL: next cycle the buffer becomes READING with rd_base=0.
  - If fill<RAC at that point: out_short pulses in that same cycle, the buffer is freed the cycle after, and rd_idx advances. No window is issued.
- While READING, out_rd_valid=1 with out_rd_buf=rd_idx, out_rd_addr=rd_base.
  - Window and valid are held stable until in_rd_ready.
  - On handshake: rd_base += STRIDE.
  - Handshake where rd_base+STRIDE+RAC > fill (last window): out_rd_valid drops next cycle, buffer goes FREE, rd_idx advances. The next FULL buffer can enter READING one cycle later.
- Window count per buffer = floor((fill-RAC)/STRIDE)+1 for fill≥RAC. With defaults, a full buffer gives 249 windows.
- Simultaneous events:
  - A seal on one buffer and a free on another in the same cycle are both applied.
  - out_full_count is updated as (+seal − free) in that cycle, registered.
  - A write stalled on a FULL/READING buffer resumes the cycle after that buffer becomes FREE.
- Wrap-around: both pointers wrap from BUFFER_COUNT-1 to 0. With all buffers FULL/READING, out_ready=0.
- Reset mid-operation discards all partial and full buffers. No write or read command is emitted after reset assertion.
- Arithmetic: fill and rd_base comparisons are performed at AW+2 bits to avoid overflow at CAP.

Decomposition:
- proj_pkg holds:
  - FM_* constants
  - fm_buf_state_e enum (FREE/FILLING/FULL/READING)
  - FM_CAP and derived widths
- One natural sub-module, proj_fm_rd_sched: the window issue FSM (rd_base counter, last-window detect, short detect, free pulse), instantiated once.
- The write side stays in the top level.

Test Plan:
- Stream 256 bytes 0x00..0xFF back-to-back, in_rd_ready=1 → out_wr_en on 256 consecutive cycles, buf 0, addr 0..255, data equal to address. Then 249 windows on buf 0, bases 0..248. Then buf 0 FREE and out_full_count returns to 0.
- in_rd_ready=0, stream 1100 bytes → out_ready falls after byte 1024 (out_full_count=4). Raise in_rd_ready → buf 0 drains. out_ready rises the cycle after buf 0 is freed, and byte 1025 is written to buf 0, addr 0.
- in_last on 20th byte → fill=20, 13 windows with bases 0..12 on buf 0. Next byte is written to buf 1, addr 0.
- in_last on 5th byte → out_short pulses once, zero windows, buf 0 freed. rd_idx=1.
- Toggle in_rd_ready randomly → out_rd_addr/out_rd_buf never change while out_rd_valid=1 and in_rd_ready=0, and no base is skipped or repeated.
- Assert in_rst_n=0 after 100 bytes, mid-window → out_wr_en=0, out_rd_valid=0 immediately, out_full_count=0. After release, the first accepted byte is written to buf 0, addr 0.

Source files
------------

// File: rtl/proj_pkg.sv
`timescale 1ns/1ps
// proj_pkg: shared constants and types for the genome frame-memory (FM)
// buffer scheduler.
//   - FM geometry constants (buffer count, RAMs, entries, bytes per entry)
//   - read-window geometry (bytes per window, window stride)
//   - derived capacity and index/address widths
//   - per-buffer state enum and the read-scheduler FSM state enum
//   - fm_next_idx: rotating buffer-pointer increment
package proj_pkg;

  localparam int FM_BUFFER_COUNT         = 4;
  localparam int FM_RAMS_COUNT           = 4;
  localparam int FM_ENTRIES_COUNT        = 16;
  localparam int FM_OFFSET_COUNT         = 4;
  localparam int FM_GENOME_BTYE          = 8;
  localparam int FM_READ_ADDRESSES_COUNT = 8;
  localparam int FM_STRIDE               = 1;

  // Bytes per buffer and the widths derived from it.
  localparam int FM_CAP = FM_RAMS_COUNT * FM_ENTRIES_COUNT * FM_OFFSET_COUNT;
  localparam int FM_AW  = $clog2(FM_CAP);
  localparam int FM_BW  = $clog2(FM_BUFFER_COUNT);

  typedef enum logic [1:0] {
    FM_FREE    = 2'd0,
    FM_FILLING = 2'd1,
    FM_FULL    = 2'd2,
    FM_READING = 2'd3
  } fm_buf_state_e;

  // Read scheduler: idle, issuing windows, or spending one cycle flagging a
  // buffer too short to yield any window.
  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_READ  = 2'd1,
    RS_SHORT = 2'd2
  } fm_rd_state_e;

  function automatic logic [FM_BW-1:0] fm_next_idx(input logic [FM_BW-1:0] idx);
    return (idx == FM_BW'(FM_BUFFER_COUNT - 1)) ? '0 : idx + FM_BW'(1);
  endfunction

endpackage

// File: rtl/proj_fm_rd_sched.sv
`timescale 1ns/1ps
// proj_fm_rd_sched: read-window issue FSM for the buffer at the read pointer.
// When the head buffer is FULL it starts reading it from base 0. A buffer
// with fewer bytes than one window raises a one-cycle o_short and is released
// the following cycle without any window. Otherwise windows are offered one
// at a time; the base advances by the stride on every handshake, and the
// handshake of the last window that still fits releases the buffer.
//
// Handshake: o_rd_valid is registered and, once high, holds together with
// o_rd_base until a cycle in which i_rd_ready is also high; that cycle is the
// transfer. i_rd_ready may toggle freely and never changes a held window.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_head_full     buffer at the read pointer is FULL
//   i_head_fill     fill of the buffer at the read pointer
//   i_rd_ready      consumer accepts the current window
//   o_rd_valid      window valid (registered)
//   o_rd_base       window base address (registered)
//   o_short         one-cycle pulse: head buffer holds less than one window
//   o_free          release the head buffer at the next edge
//   o_state         current FSM state
module proj_fm_rd_sched
  import proj_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_head_full,
  input  logic [FM_AW:0]   i_head_fill,
  input  logic             i_rd_ready,
  output logic             o_rd_valid,
  output logic [FM_AW-1:0] o_rd_base,
  output logic             o_short,
  output logic             o_free,
  output fm_rd_state_e     o_state
);

  // Comparisons run two bits wider than the address so base+stride+window
  // cannot wrap when a buffer is filled to capacity.
  localparam logic [FM_AW+1:0] RAC_X    = (FM_AW+2)'(FM_READ_ADDRESSES_COUNT);
  localparam logic [FM_AW+1:0] STRIDE_X = (FM_AW+2)'(FM_STRIDE);

  fm_rd_state_e     r_state;
  logic             r_rd_valid;
  logic [FM_AW-1:0] r_rd_base;
  logic             r_short;

  logic             w_hs;
  logic             w_last_win;
  logic             w_too_short;
  logic [FM_AW+1:0] w_base_x;
  logic [FM_AW+1:0] w_fill_x;

  assign w_base_x    = {2'b00, r_rd_base};
  assign w_fill_x    = {1'b0, i_head_fill};
  assign w_hs        = r_rd_valid && i_rd_ready;
  // The window after the current one would run past the filled bytes.
  assign w_last_win  = (w_base_x + STRIDE_X + RAC_X) > w_fill_x;
  assign w_too_short = w_fill_x < RAC_X;

  assign o_free = (r_state == RS_SHORT) ||
                  ((r_state == RS_READ) && w_hs && w_last_win);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RS_IDLE;
      r_rd_valid <= 1'b0;
      r_rd_base  <= '0;
      r_short    <= 1'b0;
    end else begin
      unique case (r_state)
        RS_IDLE: begin
          r_short <= 1'b0;
          if (i_head_full) begin
            r_rd_base <= '0;
            if (w_too_short) begin
              r_state <= RS_SHORT;
              r_short <= 1'b1;
            end else begin
              r_state    <= RS_READ;
              r_rd_valid <= 1'b1;
            end
          end
        end
        RS_SHORT: begin
          r_short <= 1'b0;
          r_state <= RS_IDLE;
        end
        RS_READ: begin
          if (w_hs) begin
            if (w_last_win) begin
              r_rd_valid <= 1'b0;
              r_state    <= RS_IDLE;
            end else begin
              r_rd_base <= r_rd_base + FM_AW'(FM_STRIDE);
            end
          end
        end
        default: begin
          r_state    <= RS_IDLE;
          r_rd_valid <= 1'b0;
          r_short    <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_base  = r_rd_base;
  assign o_short    = r_short;
  assign o_state    = r_state;

endmodule

// File: rtl/proj_fm_ctrl.sv
`timescale 1ns/1ps
// proj_fm_ctrl: buffer scheduler for the multi-buffer genome frame memory.
// Incoming bytes fill the buffer at the write pointer; each accepted byte
// becomes a registered FM write one cycle later. A buffer is sealed when its
// last address is written or when in_last marks the end of a sequence, and
// the write pointer moves on. Sealed buffers are read in write order by the
// window scheduler and released once their last window is taken.
//
// Input stream handshake: a byte transfers in any cycle where in_valid and
// out_ready are both high. out_ready depends only on registered buffer state.
//
// Ports:
//   in_clk, in_rst_n                  clock, asynchronous active-low reset
//   in_valid, in_wdata, in_last       input byte stream
//   out_ready                         write-pointer buffer can take a byte
//   out_wr_en/_buf/_addr/_data        registered FM write command
//   out_rd_valid, in_rd_ready         read-window handshake
//   out_rd_buf, out_rd_addr           window buffer index and base address
//   out_short                         pulse: sealed buffer too short to read
//   out_full_count                    buffers currently FULL or READING
module proj_fm_ctrl
  import proj_pkg::*;
(
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic                      in_valid,
  input  logic [FM_GENOME_BTYE-1:0] in_wdata,
  input  logic                      in_last,
  output logic                      out_ready,
  output logic                      out_wr_en,
  output logic [FM_BW-1:0]          out_wr_buf,
  output logic [FM_AW-1:0]          out_wr_addr,
  output logic [FM_GENOME_BTYE-1:0] out_wr_data,
  output logic                      out_rd_valid,
  input  logic                      in_rd_ready,
  output logic [FM_BW-1:0]          out_rd_buf,
  output logic [FM_AW-1:0]          out_rd_addr,
  output logic                      out_short,
  output logic [FM_BW:0]            out_full_count
);

  fm_buf_state_e             r_state [FM_BUFFER_COUNT];
  logic [FM_AW:0]            r_fill  [FM_BUFFER_COUNT];
  logic [FM_BW-1:0]          r_wr_idx;
  logic [FM_BW-1:0]          r_rd_idx;
  logic [FM_AW-1:0]          r_wr_addr;
  logic                      r_wr_en;
  logic [FM_BW-1:0]          r_wr_buf;
  logic [FM_AW-1:0]          r_wr_addr_q;
  logic [FM_GENOME_BTYE-1:0] r_wr_data;
  logic [FM_BW:0]            r_full_count;

  logic                      w_accept;
  logic                      w_seal;
  logic                      w_head_full;
  logic                      w_start;
  logic                      w_free;
  logic                      w_rd_valid;
  logic [FM_AW-1:0]          w_rd_base;
  logic                      w_short;
  fm_rd_state_e              w_rd_state;

  assign out_ready = (r_state[r_wr_idx] == FM_FREE) ||
                     (r_state[r_wr_idx] == FM_FILLING);
  assign w_accept  = in_valid && out_ready;
  assign w_seal    = w_accept &&
                     ((r_wr_addr == FM_AW'(FM_CAP - 1)) || in_last);

  assign w_head_full = (r_state[r_rd_idx] == FM_FULL);
  // Mirrors the scheduler's own start decision so the buffer flips to
  // READING on the same edge the scheduler leaves idle.
  assign w_start     = w_head_full && (w_rd_state == RS_IDLE);

  proj_fm_rd_sched u_rd_sched (
    .i_clk       (in_clk),
    .i_rst_n     (in_rst_n),
    .i_head_full (w_head_full),
    .i_head_fill (r_fill[r_rd_idx]),
    .i_rd_ready  (in_rd_ready),
    .o_rd_valid  (w_rd_valid),
    .o_rd_base   (w_rd_base),
    .o_short     (w_short),
    .o_free      (w_free),
    .o_state     (w_rd_state)
  );

  // Seal and free always hit different buffers (FREE/FILLING vs READING),
  // so both updates to r_state can land on the same edge.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < FM_BUFFER_COUNT; i++) begin
        r_state[i] <= FM_FREE;
        r_fill[i]  <= '0;
      end
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_wr_addr    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_buf     <= '0;
      r_wr_addr_q  <= '0;
      r_wr_data    <= '0;
      r_full_count <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_buf    <= r_wr_idx;
        r_wr_addr_q <= r_wr_addr;
        r_wr_data   <= in_wdata;
        if (w_seal) begin
          r_state[r_wr_idx] <= FM_FULL;
          r_fill[r_wr_idx]  <= {1'b0, r_wr_addr} + (FM_AW+1)'(1);
          r_wr_idx          <= fm_next_idx(r_wr_idx);
          r_wr_addr         <= '0;
        end else begin
          r_state[r_wr_idx] <= FM_FILLING;
          r_wr_addr         <= r_wr_addr + FM_AW'(1);
        end
      end

      if (w_start) begin
        r_state[r_rd_idx] <= FM_READING;
      end
      if (w_free) begin
        r_state[r_rd_idx] <= FM_FREE;
        r_rd_idx          <= fm_next_idx(r_rd_idx);
      end

      r_full_count <= r_full_count + {{FM_BW{1'b0}}, w_seal}
                                   - {{FM_BW{1'b0}}, w_free};
    end
  end

  assign out_wr_en      = r_wr_en;
  assign out_wr_buf     = r_wr_buf;
  assign out_wr_addr    = r_wr_addr_q;
  assign out_wr_data    = r_wr_data;
  assign out_rd_valid   = w_rd_valid;
  assign out_rd_buf     = r_rd_idx;
  assign out_rd_addr    = w_rd_base;
  assign out_short      = w_short;
  assign out_full_count = r_full_count;

endmodule

// File: tb/tb_proj_fm_ctrl.sv
`timescale 1ns/1ps
module tb_proj_fm_ctrl;
  import proj_pkg::*;

  localparam int WW  = FM_BW + FM_AW + FM_GENOME_BTYE;
  localparam int RAC = FM_READ_ADDRESSES_COUNT;

  // ---------------- clock / reset ----------------
  logic                      in_clk = 1'b0;
  logic                      in_rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic [FM_GENOME_BTYE-1:0] in_wdata = '0;
  logic                      in_last = 1'b0;
  logic                      in_rd_ready = 1'b0;
  logic                      out_ready;
  logic                      out_wr_en;
  logic [FM_BW-1:0]          out_wr_buf;
  logic [FM_AW-1:0]          out_wr_addr;
  logic [FM_GENOME_BTYE-1:0] out_wr_data;
  logic                      out_rd_valid;
  logic [FM_BW-1:0]          out_rd_buf;
  logic [FM_AW-1:0]          out_rd_addr;
  logic                      out_short;
  logic [FM_BW:0]            out_full_count;

  always #5 in_clk = ~in_clk;

  proj_fm_ctrl dut (
    .in_clk         (in_clk),
    .in_rst_n       (in_rst_n),
    .in_valid       (in_valid),
    .in_wdata       (in_wdata),
    .in_last        (in_last),
    .out_ready      (out_ready),
    .out_wr_en      (out_wr_en),
    .out_wr_buf     (out_wr_buf),
    .out_wr_addr    (out_wr_addr),
    .out_wr_data    (out_wr_data),
    .out_rd_valid   (out_rd_valid),
    .in_rd_ready    (in_rd_ready),
    .out_rd_buf     (out_rd_buf),
    .out_rd_addr    (out_rd_addr),
    .out_short      (out_short),
    .out_full_count (out_full_count)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int buf_i;
    int fill;
    int next_base;
  } sealed_t;

  logic [WW-1:0] exp_q[$];    // expected write commands, one cycle ahead
  sealed_t       seal_q[$];   // sealed buffers in write order, windows left
  int            occ;         // buffers sealed and not yet released
  int            m_wr_buf;
  int            m_wr_addr;

  int checks = 0;
  int failures = 0;
  int n_win = 0;
  int n_short = 0;

  logic p_valid, p_ready, p_short;
  logic [FM_BW-1:0] p_buf;
  logic [FM_AW-1:0] p_addr;

  logic                      obs_wr_en;
  logic [FM_BW-1:0]          obs_wr_buf;
  logic [FM_AW-1:0]          obs_wr_addr;
  logic [FM_GENOME_BTYE-1:0] obs_wr_data;
  logic [FM_BW:0]            obs_full;
  logic                      obs_ready;
  logic                      acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    seal_q.delete();
    occ = 0;
    m_wr_buf = 0;
    m_wr_addr = 0;
    p_valid = 1'b0;
    p_ready = 1'b0;
    p_short = 1'b0;
    p_buf = '0;
    p_addr = '0;
  endtask

  // ---------------- driver: one clock cycle with full checking ----------------
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic rr, output logic accepted);
    logic          hs;
    logic          do_free;
    logic [WW-1:0] e;
    sealed_t       h;
    @(negedge in_clk);
    obs_wr_en   = out_wr_en;
    obs_wr_buf  = out_wr_buf;
    obs_wr_addr = out_wr_addr;
    obs_wr_data = out_wr_data;
    obs_full    = out_full_count;
    chk("wr_en", out_wr_en, (exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (out_wr_en) chk("wr_cmd", {out_wr_buf, out_wr_addr, out_wr_data}, e);
    end
    chk("full_count", out_full_count, occ);
    if (p_valid && !p_ready) begin
      chk("hold_valid", out_rd_valid, 1);
      chk("hold_buf", out_rd_buf, p_buf);
      chk("hold_addr", out_rd_addr, p_addr);
    end
    chk("short_one_cycle", (out_short && p_short), 0);

    in_valid = v;
    in_wdata = d;
    in_last = l;
    in_rd_ready = rr;
    #1;
    obs_ready = out_ready;
    chk("ready", out_ready, (occ < FM_BUFFER_COUNT));
    accepted = v && out_ready;
    hs = out_rd_valid && rr;
    do_free = 1'b0;

    if (hs) begin
      n_win++;
      if (seal_q.size() == 0) begin
        chk("rd_spurious", hs, 0);
      end else begin
        h = seal_q[0];
        if (h.fill < RAC) begin
          chk("rd_on_short", hs, 0);
        end else begin
          chk("rd_buf", out_rd_buf, h.buf_i);
          chk("rd_addr", out_rd_addr, h.next_base);
          h.next_base = h.next_base + FM_STRIDE;
          if (h.next_base + RAC > h.fill) begin
            void'(seal_q.pop_front());
            do_free = 1'b1;
          end else begin
            seal_q[0] = h;
          end
        end
      end
    end

    if (out_short) begin
      n_short++;
      if (seal_q.size() == 0) begin
        chk("short_spurious", out_short, 0);
      end else begin
        h = seal_q[0];
        chk("short_head", out_short, (h.fill < RAC));
        if (h.fill < RAC) begin
          void'(seal_q.pop_front());
          do_free = 1'b1;
        end
      end
    end

    if (accepted) begin
      exp_q.push_back({FM_BW'(m_wr_buf), FM_AW'(m_wr_addr), d});
      if (m_wr_addr == FM_CAP - 1 || l) begin
        seal_q.push_back('{buf_i: m_wr_buf, fill: m_wr_addr + 1, next_base: 0});
        occ++;
        m_wr_buf = (m_wr_buf + 1) % FM_BUFFER_COUNT;
        m_wr_addr = 0;
      end else begin
        m_wr_addr++;
      end
    end
    if (do_free) occ--;

    p_valid = out_rd_valid;
    p_ready = rr;
    p_buf = out_rd_buf;
    p_addr = out_rd_addr;
    p_short = out_short;
    @(posedge in_clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic rr);
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 3000) begin
      cycle(1'b1, d, l, rr, acc);
      tries++;
    end
    chk("send_accepted", acc, 1);
  endtask

  task automatic drain(input int budget);
    int cnt;
    cnt = 0;
    while (seal_q.size() != 0 && cnt < budget) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
      cnt++;
    end
    chk("drain_empty", seal_q.size(), 0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(posedge in_clk);
    #2;
    in_rst_n = 1'b0;
    #1;
    chk("rst_wr_en", out_wr_en, 0);
    chk("rst_rd_valid", out_rd_valid, 0);
    chk("rst_short", out_short, 0);
    chk("rst_full_count", out_full_count, 0);
    chk("rst_ready", out_ready, 1);
    chk("rst_wr_bus", {out_wr_buf, out_wr_addr, out_wr_data}, 0);
    chk("rst_rd_bus", {out_rd_buf, out_rd_addr}, 0);
    in_valid = 1'b0;
    in_wdata = '0;
    in_last = 1'b0;
    in_rd_ready = 1'b0;
    model_clear();
    repeat (2) begin
      @(negedge in_clk);
      chk("rst_hold_wr", out_wr_en, 0);
      chk("rst_hold_rd", out_rd_valid, 0);
    end
    in_rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int len;
    bit use_last;
    int exp_win;
    int exp_short;
    int exp_next_buf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int sent, stalls, cyc;
    bit want;

    vecs[0] = '{len: 256, use_last: 1'b0, exp_win: 249, exp_short: 0, exp_next_buf: 1};
    vecs[1] = '{len: 20,  use_last: 1'b1, exp_win: 13,  exp_short: 0, exp_next_buf: 1};
    vecs[2] = '{len: 5,   use_last: 1'b1, exp_win: 0,   exp_short: 1, exp_next_buf: 1};
    vecs[3] = '{len: 8,   use_last: 1'b1, exp_win: 1,   exp_short: 0, exp_next_buf: 1};
    vecs[4] = '{len: 7,   use_last: 1'b1, exp_win: 0,   exp_short: 1, exp_next_buf: 1};
    vecs[5] = '{len: 9,   use_last: 1'b1, exp_win: 2,   exp_short: 0, exp_next_buf: 1};
    vecs[6] = '{len: 255, use_last: 1'b1, exp_win: 248, exp_short: 0, exp_next_buf: 1};
    vecs[7] = '{len: 1,   use_last: 1'b1, exp_win: 0,   exp_short: 1, exp_next_buf: 1};

    model_clear();

    // Single-sequence scenarios from the table.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      n_win = 0;
      n_short = 0;
      for (int i = 0; i < vecs[k].len; i++)
        send_byte(8'(i), vecs[k].use_last && (i == vecs[k].len - 1), 1'b1);
      drain(800);
      chk("vec_windows", n_win, vecs[k].exp_win);
      chk("vec_shorts", n_short, vecs[k].exp_short);
      chk("vec_full_count", obs_full, 0);
      send_byte(8'hC3, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
      chk("vec_next_en", obs_wr_en, 1);
      chk("vec_next_buf", obs_wr_buf, vecs[k].exp_next_buf);
      chk("vec_next_addr", obs_wr_addr, 0);
    end

    // All buffers full with the reader stalled, then released.
    do_reset();
    sent = 0;
    stalls = 0;
    cyc = 0;
    want = 1'b0;
    while (sent < 1100 && cyc < 8000) begin
      cycle(1'b1, 8'(sent), 1'b0, (stalls >= 5), acc);
      cyc++;
      if (want) begin
        chk("resume_en", obs_wr_en, 1);
        chk("resume_buf", obs_wr_buf, 0);
        chk("resume_addr", obs_wr_addr, 0);
        want = 1'b0;
      end
      if (acc) begin
        sent++;
        if (sent == 1025) want = 1'b1;
      end else begin
        if (stalls == 0) begin
          chk("stall_at", sent, 1024);
          chk("stall_full", obs_full, 4);
          chk("stall_ready", obs_ready, 0);
        end
        stalls++;
      end
    end
    chk("stall_seen", (stalls > 0), 1);
    chk("stall_sent", sent, 1100);
    send_byte(8'h77, 1'b1, 1'b1);
    drain(3000);

    // Randomized traffic with a toggling consumer.
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 1) == 1), acc);
    send_byte(8'h11, 1'b1, 1'b1);
    drain(3000);

    // Reset while a window is outstanding.
    do_reset();
    for (int i = 0; i < 100; i++)
      send_byte(8'(i), (i == 49), ($urandom_range(0, 3) == 0));
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("pre_rst_valid", p_valid, 1);
    do_reset();
    send_byte(8'hA5, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
    chk("post_rst_en", obs_wr_en, 1);
    chk("post_rst_buf", obs_wr_buf, 0);
    chk("post_rst_addr", obs_wr_addr, 0);
    chk("post_rst_data", obs_wr_data, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
